// File: rtl/event_frame_accumulator.sv
// Per-cell signed event-polarity accumulator over a timestamp window; streams the
// full grid over valid/ready when the window closes, clearing cells as they are read.
module event_frame_accumulator #(
    parameter int          GRID_BITS    = 4,
    parameter int          COUNT_BITS   = 8,
    parameter logic [15:0] WINDOW_TICKS = 16'd10000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [GRID_BITS-1:0]   x_in,
    input  logic [GRID_BITS-1:0]   y_in,
    input  logic                   polarity,
    input  logic [15:0]            timestamp,
    input  logic                   event_valid,
    input  logic                   flush,
    output logic                   frame_valid,
    input  logic                   frame_ready,
    output logic [2*GRID_BITS-1:0] cell_idx,
    output logic [COUNT_BITS-1:0]  cell_data,
    output logic                   frame_last,
    output logic                   busy,
    output logic [15:0]            drop_count
);

    localparam int IDX_W  = 2 * GRID_BITS;
    localparam int NCELLS = 1 << IDX_W;

    typedef logic signed [COUNT_BITS-1:0] cnt_t;
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_READOUT} state_t;

    localparam cnt_t CNT_MAX = cnt_t'({1'b0, {(COUNT_BITS-1){1'b1}}});
    localparam cnt_t CNT_MIN = cnt_t'({1'b1, {(COUNT_BITS-1){1'b0}}});

    state_t            state_q, state_d;
    cnt_t              cells_q [NCELLS];
    logic [15:0]       win_start_q, win_start_d;
    logic              pend_v_q, pend_v_d;
    logic [IDX_W-1:0]  pend_addr_q, pend_addr_d;
    logic              pend_pol_q, pend_pol_d;
    logic [15:0]       pend_ts_q, pend_ts_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [15:0]       drop_q, drop_d;

    logic              upd_en;
    logic [IDX_W-1:0]  upd_addr;
    logic              upd_pol;
    logic              clr_en;
    cnt_t              upd_base;
    cnt_t              upd_val;
    logic [IDX_W-1:0]  ev_addr;
    logic [15:0]       delta;
    logic              in_win;

    function automatic cnt_t sat_step(cnt_t v, logic pol);
        if (pol) return (v == CNT_MAX) ? v : v + cnt_t'(1);
        else     return (v == CNT_MIN) ? v : v - cnt_t'(1);
    endfunction

    assign ev_addr = {y_in, x_in};
    assign delta   = timestamp - win_start_q;
    assign in_win  = delta < WINDOW_TICKS;

    // A pending event replayed on the readout exit cycle may target the cell
    // being cleared in that same cycle; it must then start from zero.
    assign upd_base = (clr_en && upd_addr == idx_q) ? '0 : cells_q[upd_addr];
    assign upd_val  = sat_step(upd_base, upd_pol);

    always_comb begin
        state_d     = state_q;
        win_start_d = win_start_q;
        pend_v_d    = pend_v_q;
        pend_addr_d = pend_addr_q;
        pend_pol_d  = pend_pol_q;
        pend_ts_d   = pend_ts_q;
        idx_d       = idx_q;
        drop_d      = drop_q;
        upd_en      = 1'b0;
        upd_addr    = ev_addr;
        upd_pol     = polarity;
        clr_en      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (event_valid) begin
                    upd_en      = 1'b1;
                    win_start_d = timestamp;
                    state_d     = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (event_valid && !in_win) begin
                    pend_v_d    = 1'b1;
                    pend_addr_d = ev_addr;
                    pend_pol_d  = polarity;
                    pend_ts_d   = timestamp;
                    state_d     = S_READOUT;
                end else begin
                    upd_en = event_valid;
                    if (flush) state_d = S_READOUT;
                end
            end
            S_READOUT: begin
                if (event_valid && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
                if (frame_ready) begin
                    clr_en = 1'b1;
                    if (&idx_q) begin
                        idx_d = '0;
                        if (pend_v_q) begin
                            upd_en      = 1'b1;
                            upd_addr    = pend_addr_q;
                            upd_pol     = pend_pol_q;
                            win_start_d = pend_ts_q;
                            pend_v_d    = 1'b0;
                            state_d     = S_ACCUM;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            win_start_q <= '0;
            pend_v_q    <= 1'b0;
            pend_addr_q <= '0;
            pend_pol_q  <= 1'b0;
            pend_ts_q   <= '0;
            idx_q       <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            win_start_q <= win_start_d;
            pend_v_q    <= pend_v_d;
            pend_addr_q <= pend_addr_d;
            pend_pol_q  <= pend_pol_d;
            pend_ts_q   <= pend_ts_d;
            idx_q       <= idx_d;
            drop_q      <= drop_d;
        end
    end

    // The update write is placed after the clear so it wins on a shared address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCELLS; i++) cells_q[i] <= '0;
        end else begin
            if (clr_en) cells_q[idx_q] <= '0;
            if (upd_en) cells_q[upd_addr] <= upd_val;
        end
    end

    assign frame_valid = (state_q == S_READOUT);
    assign busy        = frame_valid;
    assign cell_idx    = idx_q;
    assign cell_data   = frame_valid ? cells_q[idx_q] : '0;
    assign frame_last  = frame_valid && (&idx_q);
    assign drop_count  = drop_q;

endmodule

// File: doc/event_frame_accumulator.md
Name: event_frame_accumulator

Overview:
- Sits directly downstream of the EVT 2.0 decoder. Consumes its registered 16x16-grid event stream (x, y, polarity, 16-bit timestamp, single-cycle valid).
- Accumulates a signed net-polarity count per grid cell over a timestamp-defined window.
- When the window closes, streams the 256-cell frame to the classifier over valid/ready and clears each cell as it is read.
- The decoder cannot be back-pressured, so events that arrive during readout are dropped and counted.

Parameters:
- GRID_BITS, 4, grid coordinate width; grid is 2^GRID_BITS square (256 cells at default).
- COUNT_BITS, 8, signed per-cell counter width.
- WINDOW_TICKS, 16'd10000, window length in timestamp units.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- x_in  input  GRID_BITS  event grid X
- y_in  input  GRID_BITS  event grid Y
- polarity  input  1  1=ON (+1), 0=OFF (-1)
- timestamp  input  16  event timestamp
- event_valid  input  1  event present this cycle
- flush  input  1  force the open window to close
- frame_valid  output  1  cell beat valid
- frame_ready  input  1  consumer accepts beat
- cell_idx  output  2*GRID_BITS  cell index = {y, x}
- cell_data  output  COUNT_BITS  signed net count of the cell
- frame_last  output  1  high on the beat with cell_idx = all ones
- busy  output  1  high in READOUT
- drop_count  output  16  events dropped, saturating at 16'hFFFF

Behaviour:
- Storage: register array of 2^(2*GRID_BITS) x COUNT_BITS signed values.
  - An update accepted in cycle N is visible from N+1.
  - Single-cycle read-modify-write, so back-to-back events to the same cell accumulate correctly.
- Counting arithmetic: ON adds 1, OFF subtracts 1.
  - Saturates at +(2^(COUNT_BITS-1))-1 and -(2^(COUNT_BITS-1)). At defaults, +127 stays +127 and -128 stays -128.
- Window delta: (timestamp - win_start) mod 2^16, a 16-bit unsigned subtraction, so timestamp wrap is handled naturally.
- Reset (asynchronous, any time including mid-readout):
  - State = IDLE; all cells = 0; win_start = 0; pending = 0; drop_count = 0.
  - Outputs: frame_valid = 0, cell_idx = 0, cell_data = 0, frame_last = 0, busy = 0.
- State machine:
  - IDLE:
    - event_valid: count the event, win_start <= timestamp, go to ACCUM.
    - flush with no event: ignored; no frame is emitted.
  - ACCUM:
    - event_valid with delta < WINDOW_TICKS: count it.
    - event_valid with delta >= WINDOW_TICKS: do not count it. Store x/y/polarity/timestamp in a one-entry pending register (pending = 1) and go to READOUT.
    - flush: go to READOUT. If an in-window event arrives in the same cycle, it is counted first.
    - If flush and an out-of-window event coincide, the event becomes pending.
  - READOUT:
    - frame_valid = 1, busy = 1.
    - cell_data shows the current array value at cell_idx, combinationally from the array and index register.
    - cell_idx starts at 0 on READOUT entry.
    - On frame_valid && frame_ready: cell[cell_idx] <= 0, cell_idx++.
    - frame_last = frame_valid && (cell_idx == all ones).
    - Outputs are held stable while frame_ready = 0.
    - event_valid in READOUT: event is dropped and drop_count increments (saturating). flush is ignored.
    - After the last beat is accepted: cell_idx <= 0.
      - If pending: count the pending event, win_start <= pending timestamp, pending <= 0, go to ACCUM.
      - Otherwise: go to IDLE.
    - An event_valid in that same exit cycle is dropped.
- Latency: the close condition in cycle N gives frame_valid high in cycle N+1. Minimum readout is 256 cycles with frame_ready held high.
- An empty cell still emits a beat with value 0; a frame is always the full 256 beats.

Test Plan:
1. Reset, then 3 ON events at (2,3) and 1 OFF at (2,3) at ts 100..103, then flush. Expect 256 beats; beat idx 0x32 = +2, all others 0; frame_last only on idx 0xFF; afterwards IDLE and busy = 0.
2. 130 ON events to (0,0), then flush. Expect cell 0 = +127. Repeat with 130 OFF events: expect -128.
3. WINDOW_TICKS = 50. Events at ts 10 (1,1) ON, ts 59 (1,1) ON, ts 60 (4,4) OFF. Expect frame with idx 0x11 = +2 and idx 0x44 = 0. Then flush: second frame has idx 0x44 = -1.
4. Window start ts 16'hFFF0, next event ts 16'h0010 with WINDOW 50 (delta 32). Expect the event counted in the same window, no close.
5. During READOUT, hold frame_ready low for 10 cycles and inject 5 events. Expect frame_valid, cell_idx and cell_data stable; drop_count = 5; frame contents unaffected.
6. Assert rst mid-readout at beat 100. Expect frame_valid = 0 and busy = 0 immediately (asynchronous); a subsequent flush emits no frame; a later single event reads back as the only nonzero cell.
